packet_checker: RTL and testbench

PACKET_CHECKER -- requirements
Module: packet_checker

---
 rtl/packet_checker.sv | 167 ++++++++++++++++
 tb/tb_packet_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_checker.sv
// AXI-Stream frame checker: validates dst MAC, keep pattern and length, counts good/bad frames.
// Define PKT_CHECKER_LATENCY_EN to build the ingress-to-completion latency tracker.
module packet_checker #(
  parameter int          AXIS_DATA_WIDTH  = 256,
  parameter int          AXIS_TUSER_WIDTH = 128,
  parameter logic [47:0] EXP_DST_MAC      = 48'h1111_1111_1111,
  parameter int          MAX_BYTES        = 2048
) (
  input  logic                         axis_aclk,
  input  logic                         axis_reset,
  input  logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  input  logic                         m_axis_tvalid,
  output logic                         m_axis_tready,
  input  logic                         m_axis_tlast,
  input  logic                         ready_en,
  input  logic [31:0]                  sync_time_ptp_ns,
  output logic [31:0]                  pkt_cnt,
  output logic [31:0]                  err_cnt,
  output logic [47:0]                  byte_cnt,
  output logic [3:0]                   err_flags,
  output logic [2:0]                   last_pcp,
  output logic                         last_vlan,
  output logic                         pkt_done,
  output logic                         pkt_err,
  output logic [31:0]                  max_latency
);
  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int LEN_W  = 32;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
  state_t state_reg, state_next;

  logic [LEN_W-1:0] byte_acc_reg;
  logic [15:0]      len_exp_reg;
  logic             hdr_vlan_reg;
  logic [2:0]       hdr_pcp_reg;
  logic [31:0]      pkt_cnt_reg, err_cnt_reg;
  logic [47:0]      byte_cnt_reg;
  logic [3:0]       err_flags_reg;
  logic [2:0]       last_pcp_reg;
  logic             last_vlan_reg, pkt_done_reg, pkt_err_reg;

  logic             beat, first, complete, frame_bad, hdr_is_vlan, cur_vlan;
  logic             keep_bad, dst_bad, over_bad, len_bad;
  logic [2:0]       cur_pcp;
  logic [3:0]       flags_new;
  logic [15:0]      exp_len;
  logic [KEEP_W-1:0] keep_plus;
  logic [LEN_W-1:0] keep_cnt, cnt_sum;
  logic [48:0]      byte_sum;

  assign m_axis_tready = ready_en & ~axis_reset;
  assign beat          = m_axis_tvalid & m_axis_tready;
  assign complete      = beat & m_axis_tlast;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_W; i++) keep_cnt = keep_cnt + LEN_W'(m_axis_tkeep[i]);
  end

  // Bytes 12..13 on the wire are 0x81,0x00, which lands as 16'h0081 in tdata[111:96].
  assign hdr_is_vlan = (m_axis_tdata[111:96] == 16'h0081);
  assign keep_plus   = m_axis_tkeep + KEEP_W'(1);

  always_comb begin
    first     = (state_reg == IDLE);
    cnt_sum   = (first ? '0 : byte_acc_reg) + keep_cnt;
    exp_len   = first ? m_axis_tuser[15:0] : len_exp_reg;
    cur_vlan  = first ? hdr_is_vlan : hdr_vlan_reg;
    cur_pcp   = first ? (hdr_is_vlan ? m_axis_tdata[119:117] : 3'd0) : hdr_pcp_reg;
    dst_bad   = first && (m_axis_tdata[47:0] != EXP_DST_MAC);
    // A last beat is legal when nonzero and of the form 0..01..1 (x & (x+1) == 0).
    keep_bad  = m_axis_tlast ? ((m_axis_tkeep == '0) || ((m_axis_tkeep & keep_plus) != '0))
                             : (m_axis_tkeep != '1);
    over_bad  = cnt_sum > LEN_W'(MAX_BYTES);
    len_bad   = m_axis_tlast && (cnt_sum != LEN_W'(exp_len));
    flags_new = (state_reg == DROP) ? 4'd0 : {dst_bad, over_bad, len_bad, keep_bad};
    frame_bad = (state_reg == DROP) || (flags_new != 4'd0);
    byte_sum  = {1'b0, byte_cnt_reg} + 49'(cnt_sum);

    state_next = state_reg;
    if (beat) begin
      case (state_reg)
        IDLE, BODY: state_next = m_axis_tlast ? IDLE : (frame_bad ? DROP : BODY);
        DROP:       state_next = m_axis_tlast ? IDLE : DROP;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      byte_acc_reg  <= '0;
      len_exp_reg   <= '0;
      hdr_vlan_reg  <= 1'b0;
      hdr_pcp_reg   <= '0;
      pkt_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      err_flags_reg <= '0;
      last_pcp_reg  <= '0;
      last_vlan_reg <= 1'b0;
      pkt_done_reg  <= 1'b0;
      pkt_err_reg   <= 1'b0;
    end else begin
      pkt_done_reg <= complete && !frame_bad;
      pkt_err_reg  <= complete && frame_bad;
      if (beat && state_reg != DROP) begin
        byte_acc_reg  <= cnt_sum;
        err_flags_reg <= err_flags_reg | flags_new;
      end
      if (beat && first) begin
        len_exp_reg  <= m_axis_tuser[15:0];
        hdr_vlan_reg <= cur_vlan;
        hdr_pcp_reg  <= cur_pcp;
      end
      if (complete && !frame_bad) begin
        if (pkt_cnt_reg != '1) pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
        byte_cnt_reg  <= byte_sum[48] ? '1 : byte_sum[47:0];
        last_pcp_reg  <= cur_pcp;
        last_vlan_reg <= cur_vlan;
      end
      if (complete && frame_bad && err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 32'd1;
    end
  end

  assign pkt_cnt   = pkt_cnt_reg;
  assign err_cnt   = err_cnt_reg;
  assign byte_cnt  = byte_cnt_reg;
  assign err_flags = err_flags_reg;
  assign last_pcp  = last_pcp_reg;
  assign last_vlan = last_vlan_reg;
  assign pkt_done  = pkt_done_reg;
  assign pkt_err   = pkt_err_reg;

`ifdef PKT_CHECKER_LATENCY_EN
  logic [31:0] ts_reg, max_lat_reg, ts_cur, lat_now;

  // Time base wraps at 1e9 ns, so a negative difference is folded back by adding 1e9.
  always_comb begin
    ts_cur  = first ? m_axis_tuser[63:32] : ts_reg;
    lat_now = sync_time_ptp_ns - ts_cur;
    if (sync_time_ptp_ns < ts_cur) lat_now = lat_now + 32'd1_000_000_000;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      ts_reg      <= '0;
      max_lat_reg <= '0;
    end else begin
      if (beat && first) ts_reg <= m_axis_tuser[63:32];
      if (complete && !frame_bad && lat_now > max_lat_reg) max_lat_reg <= lat_now;
    end
  end

  assign max_latency = max_lat_reg;
`else
  assign max_latency = 32'd0;
`endif
endmodule

// File: tb/tb_packet_checker.sv
// Directed bench for packet_checker: good/bad frames, sticky flags, oversize, backpressure, mid-frame reset.
module tb_packet_checker;
  logic         axis_aclk = 1'b0;
  logic         axis_reset;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast, ready_en;
  logic [31:0]  sync_time_ptp_ns;
  logic [31:0]  pkt_cnt, err_cnt, max_latency;
  logic [47:0]  byte_cnt;
  logic [3:0]   err_flags;
  logic [2:0]   last_pcp;
  logic         last_vlan, pkt_done, pkt_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0, err_pulses = 0, both_high = 0, illegal_acc = 0;

  localparam logic [47:0] GOOD_MAC = 48'h1111_1111_1111;

  packet_checker dut (
    .axis_aclk(axis_aclk), .axis_reset(axis_reset),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .ready_en(ready_en), .sync_time_ptp_ns(sync_time_ptp_ns),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .byte_cnt(byte_cnt), .err_flags(err_flags),
    .last_pcp(last_pcp), .last_vlan(last_vlan), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .max_latency(max_latency)
  );

  always #5 axis_aclk = ~axis_aclk;

  always @(posedge axis_aclk)
    if (m_axis_tvalid && m_axis_tready && !ready_en) illegal_acc++;

  always @(negedge axis_aclk) begin
    if (pkt_done) done_pulses++;
    if (pkt_err) err_pulses++;
    if (pkt_done && pkt_err) both_high++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Presents one beat and returns right after the posedge that accepts it.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                           input logic l, input bit bp);
    int tries = 0;
    @(negedge axis_aclk);
    m_axis_tdata = d; m_axis_tkeep = k; m_axis_tuser = u; m_axis_tlast = l; m_axis_tvalid = 1'b1;
    ready_en = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    while (!m_axis_tready) begin
      if (!ready_en) chk("tready_low", {63'd0, m_axis_tready}, 64'd0);
      tries++;
      if (tries > 200) begin
        chk("beat_timeout", 64'd1, 64'd0);
        return;
      end
      @(negedge axis_aclk);
      ready_en = (bp && tries < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
    end
    @(posedge axis_aclk);
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [2:0] pcp,
                            input int nbytes, input logic [15:0] len_field, input logic [31:0] ts,
                            input int bad_keep_beat, input bit bp, input int stop_after);
    int nbeats = (nbytes + 31) / 32;
    for (int b = 0; b < nbeats && b < stop_after; b++) begin
      logic [255:0] d;
      logic [31:0]  k;
      logic [127:0] u;
      int rem;
      d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (b == 0) begin
        d[47:0] = dst; d[103:96] = etype[15:8]; d[111:104] = etype[7:0]; d[119:117] = pcp;
      end
      k = '1;
      if (b == nbeats - 1) begin
        rem = nbytes - 32 * b;
        k = (rem == 32) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
      end
      if (b == bad_keep_beat) k = 32'hFFFF_0000;
      u = '0; u[15:0] = len_field; u[63:32] = ts;
      send_beat(d, k, u, (b == nbeats - 1), bp);
    end
  endtask

  task automatic go_idle();
    @(negedge axis_aclk);
    m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0;
  endtask

  initial begin
    axis_reset = 1'b1; ready_en = 1'b1; m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0;
    m_axis_tdata = '0; m_axis_tkeep = '0; m_axis_tuser = '0; sync_time_ptp_ns = 32'd16;
    repeat (3) @(negedge axis_aclk);
    chk("tready_in_reset", {63'd0, m_axis_tready}, 64'd0);
    axis_reset = 1'b0;
    #1;
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("rst_flags", 64'(err_flags), 64'd0);
    chk("rst_pulses", {62'd0, pkt_done, pkt_err}, 64'd0);

    // 64-byte VLAN frame, PCP 7
    send_frame(GOOD_MAC, 16'h8100, 3'd7, 64, 16'd64, 32'd0, -1, 1'b0, 1000);
    go_idle();
    chk("good_done_pulse", {63'd0, pkt_done}, 64'd1);
    chk("good_no_err_pulse", {63'd0, pkt_err}, 64'd0);
    chk("good_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("good_byte_cnt", 64'(byte_cnt), 64'd64);
    chk("good_pcp", 64'(last_pcp), 64'd7);
    chk("good_vlan", 64'(last_vlan), 64'd1);
    chk("good_flags", 64'(err_flags), 64'd0);
    @(negedge axis_aclk);
    chk("done_one_cycle", {63'd0, pkt_done}, 64'd0);

    // bad destination MAC
    send_frame(48'h0, 16'h8100, 3'd7, 64, 16'd64, 32'd0, -1, 1'b0, 1000);
    go_idle();
    chk("dst_err_pulse", {63'd0, pkt_err}, 64'd1);
    chk("dst_no_done", {63'd0, pkt_done}, 64'd0);
    chk("dst_err_cnt", 64'(err_cnt), 64'd1);
    chk("dst_flags", 64'(err_flags), 64'h8);
    chk("dst_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // middle beat with a partial keep
    send_frame(GOOD_MAC, 16'h8100, 3'd1, 96, 16'd96, 32'd0, 1, 1'b0, 1000);
    go_idle();
    chk("keep_err_cnt", 64'(err_cnt), 64'd2);
    chk("keep_flags", 64'(err_flags), 64'h9);

    // declared 100 bytes, 96 sent
    send_frame(GOOD_MAC, 16'h8100, 3'd1, 96, 16'd100, 32'd0, -1, 1'b0, 1000);
    go_idle();
    chk("len_err_cnt", 64'(err_cnt), 64'd3);
    chk("len_flags", 64'(err_flags), 64'hB);

    // single-beat untagged 20-byte frame
    send_frame(GOOD_MAC, 16'h0800, 3'd7, 20, 16'd20, 32'd0, -1, 1'b0, 1000);
    go_idle();
    chk("single_done", {63'd0, pkt_done}, 64'd1);
    chk("single_pkt_cnt", 64'(pkt_cnt), 64'd2);
    chk("single_byte_cnt", 64'(byte_cnt), 64'd84);
    chk("single_vlan", 64'(last_vlan), 64'd0);
    chk("single_pcp", 64'(last_pcp), 64'd0);

    // 2080-byte oversize frame followed back-to-back by a good frame
    send_frame(GOOD_MAC, 16'h8100, 3'd5, 2080, 16'd2080, 32'd0, -1, 1'b0, 1000);
    send_frame(GOOD_MAC, 16'h8100, 3'd3, 64, 16'd64, 32'd0, -1, 1'b0, 1000);
    go_idle();
    chk("over_err_cnt", 64'(err_cnt), 64'd4);
    chk("over_flags", 64'(err_flags), 64'hF);
    chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'd3);
    chk("b2b_byte_cnt", 64'(byte_cnt), 64'd148);
    chk("b2b_pcp", 64'(last_pcp), 64'd3);

    // backpressure, then reset in the middle of a 128-byte frame
    send_frame(GOOD_MAC, 16'h8100, 3'd2, 128, 16'd128, 32'd0, -1, 1'b1, 2);
    @(negedge axis_aclk);
    axis_reset = 1'b1;
    #1;
    chk("tready_mid_reset", {63'd0, m_axis_tready}, 64'd0);
    @(negedge axis_aclk);
    chk("mrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("mrst_err_cnt", 64'(err_cnt), 64'd0);
    chk("mrst_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("mrst_flags", 64'(err_flags), 64'd0);
    axis_reset = 1'b0; m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0;
    send_frame(GOOD_MAC, 16'h8100, 3'd6, 64, 16'd64, 32'd0, -1, 1'b1, 1000);
    go_idle();
    chk("bp_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("bp_err_cnt", 64'(err_cnt), 64'd0);
    chk("bp_byte_cnt", 64'(byte_cnt), 64'd64);
    chk("bp_pcp", 64'(last_pcp), 64'd6);

`ifdef PKT_CHECKER_LATENCY_EN
    // timestamp just before the 1e9 wrap, completion at 16 ns
    send_frame(GOOD_MAC, 16'h8100, 3'd0, 64, 16'd64, 32'd999_999_992, -1, 1'b0, 1000);
    go_idle();
    chk("lat_wrap", 64'(max_latency), 64'd24);
    send_frame(GOOD_MAC, 16'h8100, 3'd0, 64, 16'd64, 32'd6, -1, 1'b0, 1000);
    go_idle();
    chk("lat_hold_max", 64'(max_latency), 64'd24);
    chk("lat_pkt_cnt", 64'(pkt_cnt), 64'd3);
    repeat (2) @(negedge axis_aclk);
    chk("done_pulse_total", 64'(done_pulses), 64'd6);
`else
    chk("lat_off", 64'(max_latency), 64'd0);
    repeat (2) @(negedge axis_aclk);
    chk("done_pulse_total", 64'(done_pulses), 64'd4);
`endif
    chk("err_pulse_total", 64'(err_pulses), 64'd4);
    chk("pulse_overlap", 64'(both_high), 64'd0);
    chk("accept_while_stalled", 64'(illegal_acc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
